apb_master_ctrl: RTL
====================

# apb_master_ctrl

Requester-side APB (APB4-style) controller for the apb2apb bridge: accepts one command at a time over a valid/ready request channel and drives it onto the APB bus as a SETUP/ACCESS transfer. It returns read data and error status over a valid/ready response channel. It drives the bus that `apb_slave` responds on. A watchdog aborts transfers whose responder never asserts `pready`.

## Interface
- `ADDR_WIDTH`, 32, byte address width (`paddr`, `cmd_addr`)
- `DATA_WIDTH`, 32, data width; must be a multiple of 8
- `STRB_WIDTH`, `DATA_WIDTH/8`, byte-strobe width
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles without `pready` before abort; legal range ≥1

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_WIDTH  transfer address
- `cmd_wdata`  in  DATA_WIDTH  write data
- `cmd_strb`  in  STRB_WIDTH  write byte strobes
- `rsp_valid`  out  1  response present; held until taken
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors
- `rsp_slverr`  out  1  responder error, or timeout
- `rsp_timeout`  out  1  transfer aborted by watchdog
- `psel`, `penable`, `pwrite`  out  1  APB control
- `paddr`  out  ADDR_WIDTH; `pwdata`  out  DATA_WIDTH; `pstrb`  out  STRB_WIDTH
- `prdata`  in  DATA_WIDTH; `pready`  in  1; `pslverr`  in  1

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - `cmd_ready = ~rsp_valid | rsp_ready`.
  - On accept: latch addr, write, wdata and strb into the bus registers, then go to SETUP.
- **SETUP** (exactly one cycle)
  - `psel=1`, `penable=0`; go to ACCESS.
- **ACCESS**
  - `psel=1`, `penable=1`; watchdog counts ACCESS cycles.
  - On `pready=1`:
    - capture `rsp_rdata = pwrite ? 0 : prdata`, `rsp_slverr = pslverr`, `rsp_timeout = 0`.
    - `rsp_slverr=1` forces `rsp_rdata=0`.
    - Set `rsp_valid` and go to IDLE.
  - On the `TIMEOUT_CYCLES`-th ACCESS cycle with `pready=0`: set `rsp_valid`, `rsp_slverr=1`, `rsp_timeout=1`, `rsp_rdata=0`; go to IDLE.
- Bus signal rules:
  - `pstrb` is `cmd_strb` on writes and 0 on reads.
  - `paddr`, `pwrite`, `pwdata` and `pstrb` are stable from SETUP through the last ACCESS cycle.
  - All bus outputs return to 0 in IDLE.
- `cmd_ready = 0` in SETUP and ACCESS; at most one transfer is outstanding.
- `rsp_valid` clears on `rsp_valid & rsp_ready`. A response set and a response taken in the same cycle: the set wins (occurs only on IDLE accept/ACCESS completion overlap, by construction impossible).
- Watchdog counter:
  - width `$clog2(TIMEOUT_CYCLES+1)`.
  - Clears in IDLE/SETUP; saturates, never wraps.
- Reset (`rst_n=0` at a clock edge), including mid-transfer:
  - state IDLE; counter 0.
  - all bus outputs 0; `rsp_valid`, `rsp_rdata`, `rsp_slverr`, `rsp_timeout` 0.
  - `cmd_ready` forced 0 while `rst_n=0`.
  - An in-flight transfer is dropped with no response.

## Timing
- All outputs are registered except `cmd_ready` (combinational from state, `rsp_valid`, `rsp_ready`, `rst_n`).
- Accept at edge t:
  - SETUP visible t+1.
  - ACCESS t+2.
  - With `pready=1` in the first ACCESS cycle, `rsp_valid` visible t+3.
- Zero-wait throughput: one transfer per 3 cycles when `rsp_ready` is held 1.
- Each responder wait state adds one cycle.
- Timeout: `rsp_valid` visible `TIMEOUT_CYCLES` cycles after ACCESS entry.

## Structure
- Shared package `apb_master_pkg`:
  - state enum `apb_mst_state_e {IDLE, SETUP, ACCESS}`.
  - response struct (rdata, slverr, timeout).
  - default width constants aligned with `apb_arch.svh` `ADDR_WIDTH`/`DATA_WIDTH`.
- One module; the watchdog is small enough to stay inline, so no sub-module.

## Test plan
- Reset mid-ACCESS (`psel=penable=1`), deassert reset → all outputs 0, state IDLE, no `rsp_valid`; the next command proceeds normally.
- Write addr 0x10, wdata 0xDEADBEEF, strb 0xF, `pready=1` first ACCESS → `psel` at t+1, `penable` at t+2 with `pstrb=0xF`, `rsp_valid` at t+3 with `rsp_slverr=0`, `rsp_rdata=0`.
- Read addr 0x04, `pready` after 2 wait states, `prdata=0x12345678` → `pstrb=0`, `paddr` stable for 3 ACCESS cycles, `rsp_rdata=0x12345678`.
- Read with `pready=1`, `pslverr=1`, `prdata=0xFFFFFFFF` → `rsp_slverr=1`, `rsp_rdata=0`, `rsp_timeout=0`.
- `pready` held 0, `TIMEOUT_CYCLES=16` → abort after 16 ACCESS cycles; `rsp_slverr=1`, `rsp_timeout=1`, `psel=0` the following cycle.
- `rsp_ready=0` for 5 cycles after a response, `cmd_valid` held 1 → `cmd_ready=0` until `rsp_ready=1`, then accepted that cycle; the response is unchanged while held.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB requester controller.
// Width defaults match ADDR_WIDTH / DATA_WIDTH in apb_arch.svh.
package apb_master_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      slverr;
        logic                      timeout;
    } apb_mst_rsp_t;

endpackage

// File: rtl/apb_master_ctrl.sv
// APB4 requester: one command at a time over valid/ready, SETUP/ACCESS on the bus,
// response back over valid/ready, watchdog abort when pready never arrives.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    apb_mst_state_e        state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_slverr_q, rsp_slverr_d, rsp_timeout_q, rsp_timeout_d;

    // Valid/ready: a beat transfers on any rising edge where valid & ready are both 1;
    // valid is held with stable payload until that edge, ready may change freely.
    assign cmd_ready = rst_n & (state_q == IDLE) & (~rsp_valid_q | rsp_ready);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q & ~rsp_ready;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid && cmd_ready) begin
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d     = '0;
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (pready || cnt_q == CNT_LAST) begin
                    // Completion and abort share the response path; pready wins on the last cycle.
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = pready ? pslverr : 1'b1;
                    rsp_timeout_d = ~pready;
                    rsp_rdata_d   = (pready && !pwrite_q && !pslverr) ? prdata : '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwrite_d      = 1'b0;
                    paddr_d       = '0;
                    pwdata_d      = '0;
                    pstrb_d       = '0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;
    assign dbg_state   = state_q;

endmodule
